// File: rtl/oam_dma_ctrl.sv
// Sprite DMA: snoops CPU writes to $4014, halts the CPU and copies one 256-byte
// page to PPU OAM through alternating reads of {page,idx} and writes to $2004.
module oam_dma_ctrl (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_cpu_ce,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  input  logic        i_cpu_wn,
  output logic        o_cpu_halt,
  output logic        o_bus_sel,
  output logic [15:0] o_bus_addr,
  output logic [7:0]  o_bus_wdata,
  output logic        o_bus_wn,
  input  logic [7:0]  i_bus_rdata
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t      state, state_d;
  logic        odd;
  logic [7:0]  page, page_d, idx, idx_d, data, data_d;
  logic        trig;

  logic        halt_d, sel_d, wn_d;
  logic [15:0] addr_d;
  logic [7:0]  wdata_d;

  assign trig = i_cpu_ce && (state == IDLE) && (i_cpu_addr == 16'h4014) && !i_cpu_wn;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      odd   <= 1'b0;
      page  <= 8'h00;
      idx   <= 8'h00;
      data  <= 8'h00;
    end else begin
      state <= state_d;
      page  <= page_d;
      idx   <= idx_d;
      data  <= data_d;
      if (i_cpu_ce) odd <= ~odd;
    end
  end

  always_comb begin
    state_d = state;
    page_d  = page;
    idx_d   = idx;
    data_d  = data;
    if (i_cpu_ce) begin
      case (state)
        IDLE: if (trig) begin
          state_d = HALT;
          page_d  = i_cpu_wdata;
          idx_d   = 8'h00;
        end
        HALT:  state_d = odd ? ALIGN : READ;
        ALIGN: state_d = READ;
        READ: begin
          data_d  = i_bus_rdata;
          state_d = WRITE;
        end
        WRITE: begin
          if (idx == 8'hFF) state_d = IDLE;
          else begin
            idx_d   = idx + 8'h01;
            state_d = READ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from next-state values and registered, so the bus
  // sees them on the same edge the state changes and holds them between ce.
  always_comb begin
    halt_d  = (state_d != IDLE);
    sel_d   = (state_d == READ) || (state_d == WRITE);
    wn_d    = (state_d != WRITE);
    addr_d  = 16'h0000;
    wdata_d = 8'h00;
    if (state_d == READ)  addr_d = {page_d, idx_d};
    if (state_d == WRITE) begin
      addr_d  = 16'h2004;
      wdata_d = data_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_cpu_halt  <= 1'b0;
      o_bus_sel   <= 1'b0;
      o_bus_addr  <= 16'h0000;
      o_bus_wdata <= 8'h00;
      o_bus_wn    <= 1'b1;
    end else begin
      o_cpu_halt  <= halt_d;
      o_bus_sel   <= sel_d;
      o_bus_addr  <= addr_d;
      o_bus_wdata <= wdata_d;
      o_bus_wn    <= wn_d;
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: vector table, directed transfer sequences and random
// CPU traffic checked against a per-CPU-cycle expected-output queue.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wn;
  logic        halt, sel, bwn;
  logic [15:0] baddr;
  logic [7:0]  bwdata, rdata;

  int checks = 0;
  int errors = 0;

  oam_dma_ctrl dut (
    .i_clk(clk), .i_rstn(rstn), .i_cpu_ce(cpu_ce), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .i_cpu_wn(cpu_wn), .o_cpu_halt(halt),
    .o_bus_sel(sel), .o_bus_addr(baddr), .o_bus_wdata(bwdata), .o_bus_wn(bwn),
    .i_bus_rdata(rdata)
  );

  always #5 clk = ~clk;

  // Memory behind the bus mux: byte at any address is ~addr[7:0].
  assign rdata = ~baddr[7:0];

  typedef struct {
    logic        halt, sel;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wn;
    bit          wd_care;
  } exp_t;

  typedef struct {
    logic        ce;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wn;
    logic        exp_halt;
  } vec_t;

  // Model: queue of outputs the DUT must show for each upcoming CPU cycle.
  exp_t q[$];
  bit   odd_m;

  function automatic exp_t mk(logic h, logic s, logic [15:0] a, logic [7:0] d, logic w, bit c);
    exp_t e;
    e.halt = h; e.sel = s; e.addr = a; e.wdata = d; e.wn = w; e.wd_care = c;
    return e;
  endfunction

  function automatic exp_t cur_exp();
    if (q.size() > 0) return q[0];
    return mk(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1);
  endfunction

  // Build the whole transfer at trigger time: HALT, optional ALIGN, 256 pairs.
  task automatic build(input logic [7:0] page, input bit odd_at_trig);
    logic [7:0] b;
    q.push_back(mk(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1));
    if (!odd_at_trig) q.push_back(mk(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1));
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      q.push_back(mk(1'b1, 1'b1, {page, b}, 8'h00, 1'b1, 1'b0));
      q.push_back(mk(1'b1, 1'b1, 16'h2004, ~b, 1'b0, 1'b1));
    end
  endtask

  task automatic check_out(input string name);
    exp_t e;
    e = cur_exp();
    checks++;
    if (halt !== e.halt || sel !== e.sel || baddr !== e.addr || bwn !== e.wn ||
        (e.wd_care && bwdata !== e.wdata)) begin
      errors++;
      $display("FAIL %s: got halt=%b sel=%b addr=%h wdata=%h wn=%b, want halt=%b sel=%b addr=%h wdata=%h wn=%b",
               name, halt, sel, baddr, bwdata, bwn, e.halt, e.sel, e.addr, e.wdata, e.wn);
    end
  endtask

  task automatic step(input logic c, input logic [15:0] a, input logic [7:0] d, input logic w,
                      input string name);
    cpu_ce = c; cpu_addr = a; cpu_wdata = d; cpu_wn = w;
    @(posedge clk);
    #1;
    if (c) begin
      if (q.size() > 0) void'(q.pop_front());
      else if (a == 16'h4014 && !w) build(d, odd_m);
      odd_m = ~odd_m;
    end
    check_out(name);
  endtask

  task automatic idle_ce();
    step(1'b1, 16'h0000, 8'h00, 1'b1, "idle");
  endtask

  task automatic expect_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cpu_ce = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wn = 1'b1;
    q.delete();
    odd_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset");
    rstn = 1'b1;
  endtask

  // Run ce every clock until halt drops; returns number of ce seen with halt high.
  task automatic run_out(output int n);
    n = 0;
    while (halt && n < 600) begin
      idle_ce();
      n++;
    end
    if (n >= 600) begin
      errors++;
      $display("FAIL run_out: halt still high after %0d ce", n);
    end
  endtask

  vec_t vt[6];
  int   n, wcnt, bad, first_sel;
  logic [7:0] lastw;
  int   exp_len;

  initial begin
    do_reset();

    // Vector table: non-triggers, then a real trigger.
    vt[0] = '{1'b1, 16'h4014, 8'hAA, 1'b1, 1'b0};
    vt[1] = '{1'b1, 16'h4015, 8'h55, 1'b0, 1'b0};
    vt[2] = '{1'b0, 16'h4014, 8'h33, 1'b0, 1'b0};
    vt[3] = '{1'b1, 16'h0000, 8'h12, 1'b0, 1'b0};
    vt[4] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0};
    vt[5] = '{1'b1, 16'h4014, 8'h09, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      step(vt[i].ce, vt[i].addr, vt[i].wdata, vt[i].wn, "vec");
      checks++;
      if (halt !== vt[i].exp_halt) begin
        errors++;
        $display("FAIL vec%0d_halt: got %b want %b", i, halt, vt[i].exp_halt);
      end
    end
    run_out(n);

    // Even start: HALT lands on odd==0, no ALIGN, 513 cycles.
    do_reset();
    while (odd_m != 1'b1) idle_ce();
    step(1'b1, 16'h4014, 8'h02, 1'b0, "even_trig");
    idle_ce();
    first_sel = sel;
    expect_eq("even_no_align", first_sel, 1);
    n = 1;
    while (halt && n < 600) begin idle_ce(); n++; end
    expect_eq("even_len", n, 513);

    // Odd start: one ALIGN, 514 cycles.
    while (odd_m != 1'b0) idle_ce();
    step(1'b1, 16'h4014, 8'h02, 1'b0, "odd_trig");
    idle_ce();
    first_sel = sel;
    expect_eq("odd_align", first_sel, 0);
    n = 1;
    while (halt && n < 600) begin idle_ce(); n++; end
    expect_eq("odd_len", n, 514);

    // Sparse ce, page 7: last write carries byte from 0x07FF.
    step(1'b1, 16'h4014, 8'h07, 1'b0, "sparse_trig");
    wcnt = 0; lastw = 8'hAA; n = 0;
    while (halt && n < 600) begin
      step(1'b0, 16'h1234, 8'h99, 1'b0, "sparse_hold1");
      step(1'b0, 16'h4014, 8'h42, 1'b0, "sparse_hold2");
      step(1'b1, 16'h0000, 8'h00, 1'b1, "sparse_ce");
      if (!bwn) begin wcnt++; lastw = bwdata; end
      n++;
    end
    expect_eq("sparse_writes", wcnt, 256);
    expect_eq("sparse_last", int'(lastw), 0);

    // Retrigger while busy is ignored.
    exp_len = odd_m ? 513 : 514;
    step(1'b1, 16'h4014, 8'h02, 1'b0, "retrig_start");
    n = 0; bad = 0;
    while (halt && n < 600) begin
      if (n == 100) step(1'b1, 16'h4014, 8'h03, 1'b0, "retrig_write");
      else idle_ce();
      if (sel && bwn && baddr[15:8] != 8'h02) bad++;
      n++;
    end
    expect_eq("retrig_page", bad, 0);
    expect_eq("retrig_len", n, exp_len);

    // Mid-transfer reset at idx 0x80, then a fresh transfer from 0x0100.
    step(1'b1, 16'h4014, 8'h02, 1'b0, "rst_trig");
    n = 0;
    while (!(sel && bwn && baddr == 16'h0280) && n < 600) begin idle_ce(); n++; end
    expect_eq("rst_reach80", int'(baddr), 16'h0280);
    #2 rstn = 1'b0;
    q.delete();
    odd_m = 1'b0;
    #1 check_out("rst_async");
    @(posedge clk); #1 rstn = 1'b1;
    step(1'b1, 16'h4014, 8'h01, 1'b0, "rst_retrig");
    n = 0;
    while (!sel && n < 4) begin idle_ce(); n++; end
    expect_eq("rst_restart_addr", int'(baddr), 16'h0100);
    run_out(n);

    // Random CPU traffic, random ce pattern.
    for (int i = 0; i < 6000; i++) begin
      logic [15:0] a;
      case ($urandom_range(0, 3))
        0, 3:    a = 16'h4014;
        1:       a = 16'h4015;
        default: a = 16'($urandom);
      endcase
      step(1'($urandom_range(0, 1)), a, 8'($urandom), 1'($urandom_range(0, 1)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
